// File: rtl/alu_issue_stage.sv
// RV32IM OP/OP-IMM issue stage: decodes to the ALU opcode/operands and holds them in a
// registered two-entry skid buffer whose main register drives the ALU inputs directly.
module alu_issue_stage #(
    parameter int DATA_SIZE = 32,
    parameter int OP_SIZE   = 5,
    parameter int RADDR_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [DATA_SIZE-1:0] in_rs1_data,
    input  logic [DATA_SIZE-1:0] in_rs2_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_SIZE-1:0]   alu_op,
    output logic [DATA_SIZE-1:0] src1,
    output logic [DATA_SIZE-1:0] src2,
    output logic [RADDR_W-1:0]   out_rd,
    output logic                 out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [OP_SIZE-1:0] ALU_ADD    = 5'b00000;
    localparam logic [OP_SIZE-1:0] ALU_SUB    = 5'b00001;
    localparam logic [OP_SIZE-1:0] ALU_OR     = 5'b00010;
    localparam logic [OP_SIZE-1:0] ALU_AND    = 5'b00011;
    localparam logic [OP_SIZE-1:0] ALU_XOR    = 5'b00100;
    localparam logic [OP_SIZE-1:0] ALU_SLT    = 5'b01000;
    localparam logic [OP_SIZE-1:0] ALU_SLTU   = 5'b01001;
    localparam logic [OP_SIZE-1:0] ALU_SRA    = 5'b01010;
    localparam logic [OP_SIZE-1:0] ALU_SRL    = 5'b01100;
    localparam logic [OP_SIZE-1:0] ALU_SLL    = 5'b01101;
    localparam logic [OP_SIZE-1:0] ALU_MUL    = 5'b10000;
    localparam logic [OP_SIZE-1:0] ALU_MULH   = 5'b10001;
    localparam logic [OP_SIZE-1:0] ALU_MULHSU = 5'b10010;
    localparam logic [OP_SIZE-1:0] ALU_MULHU  = 5'b10011;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    assign opcode = in_instr[6:0];
    assign funct7 = in_instr[31:25];
    assign funct3 = in_instr[14:12];

    // Register source indices are resolved upstream; only the data arrives here.
    logic unused_rs_idx;
    assign unused_rs_idx = ^in_instr[24:15];

    logic [OP_SIZE-1:0]   dec_op;
    logic [DATA_SIZE-1:0] dec_src1;
    logic [DATA_SIZE-1:0] dec_src2;
    logic                 dec_ill;
    logic                 dec_shift;
    logic [DATA_SIZE-1:0] imm_sext;

    assign imm_sext = {{(DATA_SIZE-12){in_instr[31]}}, in_instr[31:20]};

    always_comb begin
        dec_op    = ALU_ADD;
        dec_src1  = in_rs1_data;
        dec_src2  = in_rs2_data;
        dec_ill   = 1'b0;
        dec_shift = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000: dec_op = ALU_ADD;
                            3'b001: begin dec_op = ALU_SLL; dec_shift = 1'b1; end
                            3'b010: dec_op = ALU_SLT;
                            3'b011: dec_op = ALU_SLTU;
                            3'b100: dec_op = ALU_XOR;
                            3'b101: begin dec_op = ALU_SRL; dec_shift = 1'b1; end
                            3'b110: dec_op = ALU_OR;
                            default: dec_op = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == 3'b000) begin
                            dec_op = ALU_SUB;
                        end else if (funct3 == 3'b101) begin
                            dec_op    = ALU_SRA;
                            dec_shift = 1'b1;
                        end else begin
                            dec_ill = 1'b1;
                        end
                    end
                    F7_MULDIV: begin
                        case (funct3)
                            3'b000:  dec_op = ALU_MUL;
                            3'b001:  dec_op = ALU_MULH;
                            3'b010:  dec_op = ALU_MULHSU;
                            3'b011:  dec_op = ALU_MULHU;
                            default: dec_ill = 1'b1;
                        endcase
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec_src2 = imm_sext;
                case (funct3)
                    3'b000: dec_op = ALU_ADD;
                    3'b001: begin
                        dec_op    = ALU_SLL;
                        dec_shift = 1'b1;
                        dec_ill   = (funct7 != F7_BASE);
                    end
                    3'b010: dec_op = ALU_SLT;
                    3'b011: dec_op = ALU_SLTU;
                    3'b100: dec_op = ALU_XOR;
                    3'b101: begin
                        dec_shift = 1'b1;
                        if (funct7 == F7_BASE) begin
                            dec_op = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_op = ALU_SRA;
                        end else begin
                            dec_ill = 1'b1;
                        end
                    end
                    3'b110: dec_op = ALU_OR;
                    default: dec_op = ALU_AND;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // The ALU shifts by the whole src2, so only the 5-bit amount may survive.
        if (dec_shift) begin
            dec_src2 = {{(DATA_SIZE-5){1'b0}}, dec_src2[4:0]};
        end
        if (dec_ill) begin
            dec_op   = ALU_ADD;
            dec_src1 = '0;
            dec_src2 = '0;
        end
    end

    logic                 main_v_q, main_v_d;
    logic [OP_SIZE-1:0]   main_op_q, main_op_d;
    logic [DATA_SIZE-1:0] main_s1_q, main_s1_d;
    logic [DATA_SIZE-1:0] main_s2_q, main_s2_d;
    logic [RADDR_W-1:0]   main_rd_q, main_rd_d;
    logic                 main_ill_q, main_ill_d;
    logic                 skid_v_q, skid_v_d;
    logic [OP_SIZE-1:0]   skid_op_q, skid_op_d;
    logic [DATA_SIZE-1:0] skid_s1_q, skid_s1_d;
    logic [DATA_SIZE-1:0] skid_s2_q, skid_s2_d;
    logic [RADDR_W-1:0]   skid_rd_q, skid_rd_d;
    logic                 skid_ill_q, skid_ill_d;
    logic                 in_ready_q;

    logic accept;
    logic drain;
    assign accept = in_valid & in_ready_q;
    assign drain  = main_v_q & out_ready;

    always_comb begin
        main_v_d   = main_v_q;
        main_op_d  = main_op_q;
        main_s1_d  = main_s1_q;
        main_s2_d  = main_s2_q;
        main_rd_d  = main_rd_q;
        main_ill_d = main_ill_q;
        skid_v_d   = skid_v_q;
        skid_op_d  = skid_op_q;
        skid_s1_d  = skid_s1_q;
        skid_s2_d  = skid_s2_q;
        skid_rd_d  = skid_rd_q;
        skid_ill_d = skid_ill_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || drain) begin
            if (skid_v_q) begin
                main_v_d   = 1'b1;
                main_op_d  = skid_op_q;
                main_s1_d  = skid_s1_q;
                main_s2_d  = skid_s2_q;
                main_rd_d  = skid_rd_q;
                main_ill_d = skid_ill_q;
                skid_v_d   = 1'b0;
            end else if (accept) begin
                main_v_d   = 1'b1;
                main_op_d  = dec_op;
                main_s1_d  = dec_src1;
                main_s2_d  = dec_src2;
                main_rd_d  = in_instr[11:7];
                main_ill_d = dec_ill;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_v_d   = 1'b1;
            skid_op_d  = dec_op;
            skid_s1_d  = dec_src1;
            skid_s2_d  = dec_src2;
            skid_rd_d  = in_instr[11:7];
            skid_ill_d = dec_ill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q   <= 1'b0;
            main_op_q  <= '0;
            main_s1_q  <= '0;
            main_s2_q  <= '0;
            main_rd_q  <= '0;
            main_ill_q <= 1'b0;
            skid_v_q   <= 1'b0;
            skid_op_q  <= '0;
            skid_s1_q  <= '0;
            skid_s2_q  <= '0;
            skid_rd_q  <= '0;
            skid_ill_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_v_q   <= main_v_d;
            main_op_q  <= main_op_d;
            main_s1_q  <= main_s1_d;
            main_s2_q  <= main_s2_d;
            main_rd_q  <= main_rd_d;
            main_ill_q <= main_ill_d;
            skid_v_q   <= skid_v_d;
            skid_op_q  <= skid_op_d;
            skid_s1_q  <= skid_s1_d;
            skid_s2_q  <= skid_s2_d;
            skid_rd_q  <= skid_rd_d;
            skid_ill_q <= skid_ill_d;
            in_ready_q <= !skid_v_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_v_q;
    assign alu_op      = main_op_q;
    assign src1        = main_s1_q;
    assign src2        = main_s2_q;
    assign out_rd      = main_rd_q;
    assign out_illegal = main_ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode vectors, buffer corner sequences, and a
// randomized run checked against a table-lookup decoder with an in-order queue.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  out_rd;
    logic        out_illegal;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_SIZE(32), .OP_SIZE(5), .RADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .src1(src1), .src2(src2),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    function automatic logic [79:0] pack_exp(exp_t e);
        return {5'b0, e.op, e.s1, e.s2, e.rd, e.ill};
    endfunction

    function automatic logic [79:0] pack_out();
        return {5'b0, alu_op, src1, src2, out_rd, out_illegal};
    endfunction

    // Reference decoder: table of legal (form, funct7, funct3) -> ALU opcode.
    typedef struct {
        logic       imm;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       care7;
        logic [4:0] op;
    } row_t;
    row_t rows[$];

    task automatic add_row(input logic imm, input logic [6:0] f7, input logic [2:0] f3,
                           input logic care7, input logic [4:0] op);
        row_t r;
        r.imm = imm; r.f7 = f7; r.f3 = f3; r.care7 = care7; r.op = op;
        rows.push_back(r);
    endtask

    function automatic exp_t model(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
        exp_t e;
        logic is_imm;
        logic [31:0] v;
        e.op = 5'd0; e.s1 = 32'd0; e.s2 = 32'd0; e.rd = ins[11:7]; e.ill = 1'b1;
        if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
            is_imm = (ins[6:0] == 7'h13);
            foreach (rows[i]) begin
                if (e.ill && rows[i].imm == is_imm && rows[i].f3 == ins[14:12] &&
                    (!rows[i].care7 || rows[i].f7 == ins[31:25])) begin
                    e.ill = 1'b0;
                    e.op  = rows[i].op;
                end
            end
            if (!e.ill) begin
                e.s1 = a;
                v = is_imm ? 32'($signed(ins) >>> 20) : b;
                if (e.op == 5'd13 || e.op == 5'd12 || e.op == 5'd10) v = v % 32;
                e.s2 = v;
            end
        end
        return e;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [4:0] op, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [4:0] rd, input logic ill);
        vec_t v;
        v.instr = instr; v.rs1 = rs1; v.rs2 = rs2;
        v.op = op; v.s1 = s1; v.s2 = s2; v.rd = rd; v.ill = ill;
        vecs.push_back(v);
    endtask

    function automatic logic [79:0] pack_vec(vec_t v);
        return {5'b0, v.op, v.s1, v.s2, v.rd, v.ill};
    endfunction

    task automatic drive(input vec_t v);
        in_instr    = v.instr;
        in_rs1_data = v.rs1;
        in_rs2_data = v.rs2;
    endtask

    exp_t exp_q[$];

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_rs1_data = '0; in_rs2_data = '0;

        add_row(0, 7'h00, 3'd0, 1, 5'h00); add_row(0, 7'h00, 3'd1, 1, 5'h0D);
        add_row(0, 7'h00, 3'd2, 1, 5'h08); add_row(0, 7'h00, 3'd3, 1, 5'h09);
        add_row(0, 7'h00, 3'd4, 1, 5'h04); add_row(0, 7'h00, 3'd5, 1, 5'h0C);
        add_row(0, 7'h00, 3'd6, 1, 5'h02); add_row(0, 7'h00, 3'd7, 1, 5'h03);
        add_row(0, 7'h20, 3'd0, 1, 5'h01); add_row(0, 7'h20, 3'd5, 1, 5'h0A);
        add_row(0, 7'h01, 3'd0, 1, 5'h10); add_row(0, 7'h01, 3'd1, 1, 5'h11);
        add_row(0, 7'h01, 3'd2, 1, 5'h12); add_row(0, 7'h01, 3'd3, 1, 5'h13);
        add_row(1, 7'h00, 3'd0, 0, 5'h00); add_row(1, 7'h00, 3'd2, 0, 5'h08);
        add_row(1, 7'h00, 3'd3, 0, 5'h09); add_row(1, 7'h00, 3'd4, 0, 5'h04);
        add_row(1, 7'h00, 3'd6, 0, 5'h02); add_row(1, 7'h00, 3'd7, 0, 5'h03);
        add_row(1, 7'h00, 3'd1, 1, 5'h0D); add_row(1, 7'h00, 3'd5, 1, 5'h0C);
        add_row(1, 7'h20, 3'd5, 1, 5'h0A);

        //       instr         rs1           rs2           op     src1          src2          rd  ill
        add_vec(32'h002081B3, 32'd5,        32'd7,        5'h00, 32'd5,        32'd7,        3,  0); // add
        add_vec(32'hFFF00093, 32'd0,        32'd0,        5'h00, 32'd0,        32'hFFFFFFFF, 1,  0); // addi -1
        add_vec(32'h4210D093, 32'h1234,     32'd0,        5'h00, 32'd0,        32'd0,        1,  1); // srai 33
        add_vec(32'h002091B3, 32'hF0,       32'h123,      5'h0D, 32'hF0,       32'd3,        3,  0); // sll
        add_vec(32'h41F0D093, 32'h80000000, 32'd0,        5'h0A, 32'h80000000, 32'd31,       1,  0); // srai 31
        add_vec(32'h0220C1B3, 32'd9,        32'd3,        5'h00, 32'd0,        32'd0,        3,  1); // div
        add_vec(32'h0220A1B3, 32'd6,        32'd7,        5'h12, 32'd6,        32'd7,        3,  0); // mulhsu
        add_vec(32'h402081B3, 32'd10,       32'd4,        5'h01, 32'd10,       32'd4,        3,  0); // sub
        add_vec(32'h7FF0B293, 32'd1,        32'd0,        5'h09, 32'd1,        32'h7FF,      5,  0); // sltiu
        add_vec(32'h123450B7, 32'd1,        32'd2,        5'h00, 32'd0,        32'd0,        1,  1); // lui
        add_vec(32'h40109093, 32'd1,        32'd2,        5'h00, 32'd0,        32'd0,        1,  1); // slli bad f7
        add_vec(32'h0020D1B3, 32'd7,        32'hFFFFFFE5, 5'h0C, 32'd7,        32'd5,        3,  0); // srl

        #12;
        chk("reset_out_valid", 80'(out_valid), 80'd0);
        chk("reset_in_ready", 80'(in_ready), 80'd1);
        chk("reset_fields", pack_out(), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed decode vectors, one at a time with the sink always ready.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 80'(out_valid), 80'd1);
            chk($sformatf("vec%0d_fields", i), pack_out(), pack_vec(vecs[i]));
        end
        @(negedge clk);
        chk("idle_valid", 80'(out_valid), 80'd0);

        // Back-to-back with a stalled sink: two accepted, third waits for in_ready.
        out_ready = 1'b0;
        drive(vecs[0]); in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_ready_after_1", 80'(in_ready), 80'd1);
        drive(vecs[3]);
        @(negedge clk);
        chk("b2b_ready_after_2", 80'(in_ready), 80'd0);
        drive(vecs[6]);
        @(negedge clk);
        chk("b2b_stall_ready", 80'(in_ready), 80'd0);
        chk("b2b_stall_head", pack_out(), pack_vec(vecs[0]));
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_second", pack_out(), pack_vec(vecs[3]));
        chk("b2b_ready_back", 80'(in_ready), 80'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_third", pack_out(), pack_vec(vecs[6]));
        chk("b2b_third_valid", 80'(out_valid), 80'd1);
        @(negedge clk);
        chk("b2b_empty", 80'(out_valid), 80'd0);

        // Flush with both entries held and a new valid on the flush edge.
        out_ready = 1'b0;
        drive(vecs[0]); in_valid = 1'b1;
        @(negedge clk);
        drive(vecs[7]);
        @(negedge clk);
        drive(vecs[8]); flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 80'(out_valid), 80'd0);
        chk("flush_ready", 80'(in_ready), 80'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_stays_empty", 80'(out_valid), 80'd0);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        drive(vecs[4]); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("prereset_valid", 80'(out_valid), 80'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 80'(out_valid), 80'd0);
        chk("async_reset_fields", pack_out(), 80'd0);
        chk("async_reset_ready", 80'(in_ready), 80'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the reference decoder and an in-order queue.
        exp_q.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            chk("rnd_out_valid", 80'(out_valid), 80'(exp_q.size() > 0));
            chk("rnd_in_ready", 80'(in_ready), 80'(exp_q.size() < 2));
            if (exp_q.size() > 0) chk("rnd_head", pack_out(), pack_exp(exp_q[0]));

            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            in_instr    = $urandom;
            case ($urandom_range(0, 7))
                0, 1, 2: in_instr[6:0] = 7'h33;
                3, 4, 5: in_instr[6:0] = 7'h13;
                default: ;
            endcase
            case ($urandom_range(0, 4))
                0, 1: in_instr[31:25] = 7'h00;
                2:    in_instr[31:25] = 7'h20;
                3:    in_instr[31:25] = 7'h01;
                default: ;
            endcase

            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                if (in_valid && in_ready)
                    exp_q.push_back(model(in_instr, in_rs1_data, in_rs2_data));
            end
        end
        flush = 1'b0; in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
